fu_branch_resolver: RTL

- Requester/driver end of the fu_branch_predictor_if protocol; the BTB is the responder end.
- Owns the fetch PC register and presents it to the BTB each cycle for lookup.
- Steers the next fetch PC from the BTB prediction.
- Resolves branches/jumps issued from execute, drives BTB update pulses, and raises a one-cycle flush with redirect on mispredict.

---
 rtl/fu_branch_resolver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fu_branch_resolver.sv
// Fetch-PC owner and branch resolver: steers fetch from BTB predictions, resolves execute-stage
// branches/jumps, strobes BTB updates and flushes on mispredict. BR_PERF_CNT_EN adds perf counters.
module fu_branch_resolver #(
    parameter int unsigned       WORD_W   = 32,
    parameter logic [WORD_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_INC   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              fetch_stall,
    output logic [WORD_W-1:0] pc,
    input  logic              predicted_outcome,
    input  logic [WORD_W-1:0] predicted_target,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] ex_pc,
    input  logic [WORD_W-1:0] ex_rs1,
    input  logic [WORD_W-1:0] ex_rs2,
    input  logic [WORD_W-1:0] ex_imm,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_jal,
    input  logic              ex_jalr,
    input  logic              ex_pred_taken,
    input  logic [WORD_W-1:0] ex_pred_target,
    output logic              update_btb,
    output logic [WORD_W-1:0] update_pc,
    output logic              branch_outcome,
    output logic [WORD_W-1:0] branch_target,
    output logic              flush,
    output logic [WORD_W-1:0] redirect_pc
`ifdef BR_PERF_CNT_EN
    ,
    output logic [31:0]       perf_resolved,
    output logic [31:0]       perf_mispredict
`endif
);

    localparam logic [WORD_W-1:0] INC        = WORD_W'(PC_INC);
    localparam logic [WORD_W-1:0] ALIGN_MASK = ~WORD_W'(1);

    logic [WORD_W-1:0] r_pc;
    logic              r_update_btb;
    logic [WORD_W-1:0] r_update_pc;
    logic              r_branch_outcome;
    logic [WORD_W-1:0] r_branch_target;
    logic              r_flush;
    logic [WORD_W-1:0] r_redirect_pc;

    logic              w_accept;
    logic              w_taken;
    logic [WORD_W-1:0] w_target;
    logic              w_mispredict;
    logic [WORD_W-1:0] w_redirect;
    logic [WORD_W-1:0] w_pc_next;

    // Anything presented while the flush pulse is high is a squashed younger instruction.
    assign w_accept = ex_valid & ~r_flush;

    always_comb begin
        w_taken = 1'b0;
        if (ex_jal || ex_jalr) begin
            w_taken = 1'b1;
        end else begin
            unique case (ex_funct3)
                3'b000:  w_taken = (ex_rs1 == ex_rs2);
                3'b001:  w_taken = (ex_rs1 != ex_rs2);
                3'b100:  w_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
                3'b101:  w_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
                3'b110:  w_taken = (ex_rs1 <  ex_rs2);
                3'b111:  w_taken = (ex_rs1 >= ex_rs2);
                default: w_taken = 1'b0;
            endcase
        end
    end

    assign w_target     = ex_jalr ? ((ex_rs1 + ex_imm) & ALIGN_MASK) : (ex_pc + ex_imm);
    assign w_mispredict = (w_taken != ex_pred_taken) || (w_taken && (w_target != ex_pred_target));
    assign w_redirect   = w_taken ? w_target : (ex_pc + INC);

    always_comb begin
        w_pc_next = r_pc;
        if (r_flush) begin
            w_pc_next = r_redirect_pc;
        end else if (!fetch_stall) begin
            w_pc_next = predicted_outcome ? predicted_target : (r_pc + INC);
        end
    end

    // Fetch PC and registered resolution results.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc             <= RESET_PC;
            r_update_btb     <= 1'b0;
            r_update_pc      <= '0;
            r_branch_outcome <= 1'b0;
            r_branch_target  <= '0;
            r_flush          <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_pc         <= w_pc_next;
            r_update_btb <= w_accept;
            r_flush      <= w_accept & w_mispredict;
            if (w_accept) begin
                r_update_pc      <= ex_pc;
                r_branch_outcome <= w_taken;
                r_branch_target  <= w_target;
            end
            if (w_accept && w_mispredict) begin
                r_redirect_pc <= w_redirect;
            end
        end
    end

    assign pc             = r_pc;
    assign update_btb     = r_update_btb;
    assign update_pc      = r_update_pc;
    assign branch_outcome = r_branch_outcome;
    assign branch_target  = r_branch_target;
    assign flush          = r_flush;
    assign redirect_pc    = r_redirect_pc;

`ifdef BR_PERF_CNT_EN
    logic [31:0] r_perf_resolved;
    logic [31:0] r_perf_mispredict;

    // Counters advance on the same edge that raises the corresponding pulse, saturating at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_perf_resolved   <= '0;
            r_perf_mispredict <= '0;
        end else begin
            if (w_accept && (r_perf_resolved != 32'hFFFF_FFFF)) begin
                r_perf_resolved <= r_perf_resolved + 32'd1;
            end
            if (w_accept && w_mispredict && (r_perf_mispredict != 32'hFFFF_FFFF)) begin
                r_perf_mispredict <= r_perf_mispredict + 32'd1;
            end
        end
    end

    assign perf_resolved   = r_perf_resolved;
    assign perf_mispredict = r_perf_mispredict;
`endif

endmodule
